rr_axil_csr_file: RTL
=====================

Name: rr_axil_csr_file

Overview:
Parametrised AXI-Lite CSR file, next generation of the record/replay config-register block. Register count, per-register access type (RW, RO, write-pulse) and reset values are parameters. The register map is no longer hard-coded. Adds SLVERR responses for illegal accesses and one-cycle write strobes. Sits between the OCL/BAR1 AXI-Lite config bus and the record/replay control logic (tracestorage, mode control).

Parameters:
N_REGS, 64, number of 32-bit CSRs; legal range 2..1024.
RO_MASK, {N_REGS{1'b0}}, bit i=1: register i is read-only and mirrors ro_in.
PULSE_MASK, {N_REGS{1'b0}}, bit i=1: register i is write-pulse; a write produces wr_pulse[i] and nothing is stored. Must not overlap RO_MASK.
RESET_VALS, {N_REGS*32{1'b0}}, reset value of RW register i at bits [i*32 +: 32].
Derived localparam: AW = $clog2(N_REGS).

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
awvalid  in  1  write address valid
awready  out  1  write address ready
awaddr  in  32  byte address
wvalid  in  1  write data valid
wready  out  1  write data ready
wdata  in  32  write data
wstrb  in  4  byte strobes
bvalid  out  1  write response valid
bready  in  1  write response ready
bresp  out  2  0=OKAY, 2=SLVERR
arvalid  in  1  read address valid
arready  out  1  read address ready
araddr  in  32  byte address
rvalid  out  1  read data valid
rready  in  1  read data ready
rdata  out  32  read data
rresp  out  2  0=OKAY, 2=SLVERR
reg_out  out  N_REGS*32  current value of every register
ro_in  in  N_REGS*32  status inputs for RO registers
wr_pulse  out  N_REGS  one-cycle strobe per accepted legal write

Behaviour:
- Reset (async assert, sync release):
  - awready, wready, bvalid, rvalid, rdata, bresp, rresp, wr_pulse = 0.
  - RW regs = RESET_VALS; RO and pulse regs read 0.
  - Any in-flight transaction is dropped; no response is issued for it.
- Decode: idx = addr[2 +: AW]. Access is illegal if addr[31:2+AW] != 0 or idx >= N_REGS. addr[1:0] is ignored.
- Write channel:
  - awready = ~aw_held & ~bvalid; wready = ~w_held & ~bvalid.
  - AW and W are accepted independently, in either order or in the same cycle. The first one accepted is held until the other arrives.
  - At most one write is outstanding.
- Write commit happens at the edge after the second handshake completes (edge E+1):
  - RW register: reg <= (wdata & strb_ext) | (reg & ~strb_ext), with strb_ext = each wstrb bit replicated 8x. Response OKAY.
  - Pulse register: wr_pulse[idx] = 1 for exactly the cycle after E+1; stores nothing; OKAY.
  - RO register or illegal address: no state change, no pulse, SLVERR.
  - RW write: wr_pulse[idx] also asserts for one cycle.
  - bvalid rises at E+1 and holds until bready; aw_held and w_held clear at E+1.
- Read channel:
  - arready = ~rvalid.
  - On the AR handshake edge: capture rdata and rresp; rvalid = 1 next cycle; held stable until rready.
  - Read returns: RW = stored value; RO = ro_in slice registered one stage; pulse = 0; illegal = 0 with SLVERR.
- Read and write commit to the same register on the same edge: the read returns the pre-write value.
- RO status: the registered ro_in stage updates every cycle, independent of bus activity.
- reg_out: driven directly from storage. RO slices carry the registered ro_in; pulse slices are 0.
- Back-to-back: a new write can be accepted the cycle after the B handshake completes. Worst-case write throughput is 1 per 3 cycles when bready is held high.

Test Plan:
- N_REGS=64, write 0xDEADBEEF to 0x10 with AW/W in the same cycle, then read 0x10 -> bresp=0 and bvalid one cycle after the handshake; rdata=0xDEADBEEF, rresp=0.
- Reg 4 holds 0xFFFFFFFF; write 0x12345678 with wstrb=4'b0101 -> read returns 0xFF34FF78.
- AW first, W issued 3 cycles later, with bready held low for 5 cycles -> awready/wready stay low until the B handshake; a single response; register updated once.
- PULSE_MASK bit 7 set, write 0x1C -> wr_pulse[7] high for exactly 1 cycle; read 0x1C returns 0. RO bit 2 set with ro_in slice = 0xA5A5 -> write 0x08 gives SLVERR, read returns 0xA5A5.
- Read 0x100 and write 0x400 with N_REGS=64 -> rresp=2 with rdata=0; bresp=2; reg_out unchanged.
- Assert rstn mid-write (AW held, W pending) -> bvalid=0, reg_out=RESET_VALS; a subsequent full write completes normally.

Source files
------------

// File: rtl/rr_axil_csr_file.sv
// Parametrised AXI-Lite CSR file with RW / RO / write-pulse registers.
// Ports: AXI-Lite slave (aw/w/b/ar/r), reg_out, ro_in, wr_pulse.
module rr_axil_csr_file #(
    parameter int                    N_REGS     = 64,
    parameter logic [N_REGS-1:0]     RO_MASK    = '0,
    parameter logic [N_REGS-1:0]     PULSE_MASK = '0,
    parameter logic [N_REGS*32-1:0]  RESET_VALS = '0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [31:0]            awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [31:0]            wdata,
    input  logic [3:0]             wstrb,
    output logic                   bvalid,
    input  logic                   bready,
    output logic [1:0]             bresp,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [31:0]            araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [31:0]            rdata,
    output logic [1:0]             rresp,
    output logic [N_REGS*32-1:0]   reg_out,
    input  logic [N_REGS*32-1:0]   ro_in,
    output logic [N_REGS-1:0]      wr_pulse
);

    localparam int AW = $clog2(N_REGS);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic          active;
    logic          aw_held;
    logic          w_held;
    logic [31:0]   waddr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic [31:0]   strb_ext;
    logic [AW-1:0] widx;
    logic [AW-1:0] ridx;
    logic          commit;
    logic          w_ok;
    logic [31:0]   val [N_REGS];

    // Low address bits and non-RO status inputs are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{ro_in, waddr_q[1:0], araddr[1:0]};

    function automatic logic addr_ok(input logic [31:0] a);
        logic [31:0] hi;
        logic [31:0] idx;
        hi  = a >> (2 + AW);
        idx = 32'(a[2 +: AW]);
        return (hi == 32'd0) && (idx < 32'(N_REGS));
    endfunction

    // Ready stays low while in reset and for the first cycle after release.
    assign awready = active & ~aw_held & ~bvalid;
    assign wready  = active & ~w_held & ~bvalid;
    assign arready = active & ~rvalid;

    assign commit   = aw_held & w_held;
    assign widx     = waddr_q[2 +: AW];
    assign ridx     = araddr[2 +: AW];
    assign w_ok     = addr_ok(waddr_q) && !RO_MASK[widx];
    assign strb_ext = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}},
                       {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            active   <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bvalid   <= 1'b0;
            bresp    <= OKAY;
            wr_pulse <= '0;
        end else begin
            active   <= 1'b1;
            wr_pulse <= '0;
            if (awvalid && awready) begin
                aw_held <= 1'b1;
                waddr_q <= awaddr;
            end
            if (wvalid && wready) begin
                w_held  <= 1'b1;
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= w_ok ? OKAY : SLVERR;
                if (w_ok)
                    wr_pulse[widx] <= 1'b1;
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    // Read data is sampled from storage before any same-edge write lands.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= OKAY;
        end else if (arvalid && arready) begin
            rvalid <= 1'b1;
            if (addr_ok(araddr)) begin
                rdata <= val[ridx];
                rresp <= OKAY;
            end else begin
                rdata <= '0;
                rresp <= SLVERR;
            end
        end else if (rvalid && rready) begin
            rvalid <= 1'b0;
        end
    end

    for (genvar i = 0; i < N_REGS; i++) begin : g_reg
        if (RO_MASK[i]) begin : g_ro
            logic [31:0] ro_q;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)
                    ro_q <= '0;
                else
                    ro_q <= ro_in[i*32 +: 32];
            end
            assign val[i] = ro_q;
        end else if (PULSE_MASK[i]) begin : g_pulse
            assign val[i] = '0;
        end else begin : g_rw
            logic [31:0] q;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)
                    q <= RESET_VALS[i*32 +: 32];
                else if (commit && w_ok && widx == AW'(i))
                    q <= (wdata_q & strb_ext) | (q & ~strb_ext);
            end
            assign val[i] = q;
        end
        assign reg_out[i*32 +: 32] = val[i];
    end

endmodule
